// File: rtl/aurora_rx_checker.sv
// Receive-side pattern checker: compares each 256-bit beat against seed + 8*k + j.
// Optional watchdog abort is compiled in with `define CHK_TIMEOUT_EN.
module aurora_rx_checker #(
    parameter int unsigned TIMEOUT_CYC = 32'd1048576
) (
    input  logic         ap_clk,
    input  logic         ap_rst_n,
    input  logic         rx_axis_tvalid,
    input  logic [255:0] rx_axis_tdata,
    output logic         rx_axis_tready,
    input  logic         start,
    input  logic [31:0]  beat_num,
    input  logic [31:0]  seed,
    output logic         busy,
    output logic         done,
    output logic [31:0]  beat_cnt,
    output logic [31:0]  err_cnt,
    output logic [31:0]  first_err_idx,
    output logic         timeout
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t         state_q, state_d;
    logic [31:0]    beat_num_q, beat_num_d;
    logic [31:0]    seed_q, seed_d;
    logic [31:0]    beat_cnt_q, beat_cnt_d;
    logic [31:0]    err_cnt_q, err_cnt_d;
    logic [31:0]    first_err_q, first_err_d;

    logic           s1_valid_q, s1_valid_d;
    logic [255:0]   s1_data_q, s1_data_d;
    logic [31:0]    s1_idx_q, s1_idx_d;
    logic           s2_valid_q, s2_valid_d;
    logic           s2_err_q, s2_err_d;
    logic [31:0]    s2_idx_q, s2_idx_d;

    logic           hs;
    logic           mismatch;

`ifdef CHK_TIMEOUT_EN
    logic [31:0]    idle_cnt_q, idle_cnt_d;
    logic           timeout_q, timeout_d;
`endif

    assign hs = (state_q == RUN) && rx_axis_tvalid;

    // Stage 2 compare: expected word is rebuilt from the beat index held in stage 1.
    always_comb begin
        mismatch = 1'b0;
        for (int unsigned j = 0; j < 8; j++) begin
            if (s1_data_q[32*j +: 32] != (seed_q + (s1_idx_q << 3) + 32'(j)))
                mismatch = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        beat_num_d  = beat_num_q;
        seed_d      = seed_q;
        beat_cnt_d  = beat_cnt_q;
        err_cnt_d   = err_cnt_q;
        first_err_d = first_err_q;

        s1_valid_d  = hs;
        s1_data_d   = hs ? rx_axis_tdata : s1_data_q;
        s1_idx_d    = hs ? beat_cnt_q : s1_idx_q;
        s2_valid_d  = s1_valid_q;
        s2_err_d    = s1_valid_q & mismatch;
        s2_idx_d    = s1_idx_q;
`ifdef CHK_TIMEOUT_EN
        idle_cnt_d  = idle_cnt_q;
        timeout_d   = timeout_q;
`endif

        if (s2_valid_q && s2_err_q) begin
            if (err_cnt_q != '1)
                err_cnt_d = err_cnt_q + 32'd1;
            if (first_err_q == '1)
                first_err_d = s2_idx_q;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    beat_cnt_d  = '0;
                    err_cnt_d   = '0;
                    first_err_d = '1;
`ifdef CHK_TIMEOUT_EN
                    timeout_d   = 1'b0;
                    idle_cnt_d  = '0;
`endif
                    if (beat_num != '0) begin
                        state_d    = RUN;
                        beat_num_d = beat_num;
                        seed_d     = seed;
                    end else begin
                        state_d    = DONE;
                    end
                end
            end
            RUN: begin
                if (hs) begin
                    beat_cnt_d = beat_cnt_q + 32'd1;
`ifdef CHK_TIMEOUT_EN
                    idle_cnt_d = '0;
`endif
                    if (beat_cnt_q == beat_num_q - 32'd1)
                        state_d = DRAIN;
                end
`ifdef CHK_TIMEOUT_EN
                else if (idle_cnt_q == TIMEOUT_CYC - 32'd1) begin
                    timeout_d = 1'b1;
                    state_d   = DRAIN;
                end else begin
                    idle_cnt_d = idle_cnt_q + 32'd1;
                end
`endif
            end
            // Leaving when stage 1 is empty lets the last stage-2 commit land on the same edge.
            DRAIN: begin
                if (!s1_valid_q)
                    state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q     <= IDLE;
            beat_num_q  <= '0;
            seed_q      <= '0;
            beat_cnt_q  <= '0;
            err_cnt_q   <= '0;
            first_err_q <= '1;
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            s1_idx_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_err_q    <= 1'b0;
            s2_idx_q    <= '0;
`ifdef CHK_TIMEOUT_EN
            idle_cnt_q  <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            beat_num_q  <= beat_num_d;
            seed_q      <= seed_d;
            beat_cnt_q  <= beat_cnt_d;
            err_cnt_q   <= err_cnt_d;
            first_err_q <= first_err_d;
            s1_valid_q  <= s1_valid_d;
            s1_data_q   <= s1_data_d;
            s1_idx_q    <= s1_idx_d;
            s2_valid_q  <= s2_valid_d;
            s2_err_q    <= s2_err_d;
            s2_idx_q    <= s2_idx_d;
`ifdef CHK_TIMEOUT_EN
            idle_cnt_q  <= idle_cnt_d;
            timeout_q   <= timeout_d;
`endif
        end
    end

    assign rx_axis_tready = (state_q == RUN);
    assign busy           = (state_q == RUN) || (state_q == DRAIN);
    assign done           = (state_q == DONE);
    assign beat_cnt       = beat_cnt_q;
    assign err_cnt        = err_cnt_q;
    assign first_err_idx  = first_err_q;
`ifdef CHK_TIMEOUT_EN
    assign timeout        = timeout_q;
`else
    assign timeout        = 1'b0;
`endif

endmodule

// File: tb/tb_aurora_rx_checker.sv
// Scoreboard bench for aurora_rx_checker; watchdog scenario follows CHK_TIMEOUT_EN.
module tb_aurora_rx_checker;

    logic         ap_clk = 1'b0;
    logic         ap_rst_n = 1'b0;
    logic         rx_axis_tvalid = 1'b0;
    logic [255:0] rx_axis_tdata = '0;
    logic         rx_axis_tready;
    logic         start = 1'b0;
    logic [31:0]  beat_num = '0;
    logic [31:0]  seed = '0;
    logic         busy, done, timeout;
    logic [31:0]  beat_cnt, err_cnt, first_err_idx;

    aurora_rx_checker #(.TIMEOUT_CYC(16)) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .rx_axis_tvalid(rx_axis_tvalid), .rx_axis_tdata(rx_axis_tdata),
        .rx_axis_tready(rx_axis_tready), .start(start), .beat_num(beat_num),
        .seed(seed), .busy(busy), .done(done), .beat_cnt(beat_cnt),
        .err_cnt(err_cnt), .first_err_idx(first_err_idx), .timeout(timeout)
    );

    always #5 ap_clk = ~ap_clk;

    int unsigned cyc = 0;
    always @(posedge ap_clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] bc;
        logic [31:0] ec;
        logic [31:0] fe;
        logic        to;
    } exp_t;
    exp_t sb[$];

    function automatic logic [255:0] mk_beat(input logic [31:0] sd, input logic [31:0] k, input logic bad);
        logic [255:0] b;
        for (int j = 0; j < 8; j++) b[32*j +: 32] = sd + (k << 3) + 32'(j);
        if (bad) b[255:224] = ~b[255:224];
        return b;
    endfunction

    // Drives one run; pushes the model's expected end-of-run results when push is set.
    task automatic drive_run(input logic [31:0] sd, input logic [31:0] n, input logic [31:0] nsend,
                             input logic [31:0] mask, input bit gaps, input bit noise, input bit exp_to,
                             input bit push, output int unsigned start_cyc, output int unsigned last_cyc);
        exp_t e;
        int unsigned k, guard;
        bit v;
        e.bc = nsend; e.ec = '0; e.fe = '1; e.to = exp_to;
        for (int unsigned i = 0; i < nsend; i++) begin
            if (i < 32 && mask[i]) begin
                e.ec = e.ec + 1;
                if (e.fe == '1) e.fe = i;
            end
        end
        if (push) sb.push_back(e);
        @(negedge ap_clk);
        start = 1'b1; beat_num = n; seed = sd; start_cyc = cyc;
        @(negedge ap_clk);
        start = 1'b0;
        k = 0; guard = 0; last_cyc = cyc;
        while (k < nsend && guard < 4000) begin
            v = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (noise && $urandom_range(0, 3) == 0) begin
                start = 1'b1; beat_num = $urandom; seed = $urandom;
            end else begin
                start = 1'b0;
            end
            rx_axis_tvalid = v;
            rx_axis_tdata  = mk_beat(sd, k, (k < 32) && mask[k]);
            if (v && rx_axis_tready) begin
                last_cyc = cyc;
                k++;
            end
            @(negedge ap_clk);
            guard++;
        end
        rx_axis_tvalid = 1'b0; start = 1'b0; beat_num = n; seed = sd;
        n_cmp++;
        if (k !== nsend) begin n_err++; $display("FAIL beats_accepted: got %0d want %0d", k, nsend); end
    endtask

    task automatic collect(output bit got, output int unsigned at, output bit still_high);
        got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (done) begin got = 1'b1; break; end
            @(negedge ap_clk);
        end
        at = cyc;
        @(negedge ap_clk);
        still_high = done;
    endtask

    task automatic test_reset;
        ap_rst_n = 1'b0;
        repeat (2) @(negedge ap_clk);
        n_cmp++; if (rx_axis_tready !== 1'b0) begin n_err++; $display("FAIL rst_tready: got %b want 0", rx_axis_tready); end
        n_cmp++; if ({busy, done, timeout} !== 3'b000) begin n_err++; $display("FAIL rst_flags: got %b want 000", {busy, done, timeout}); end
        n_cmp++; if (beat_cnt !== 32'd0 || err_cnt !== 32'd0) begin n_err++; $display("FAIL rst_counts: got %h/%h want 0/0", beat_cnt, err_cnt); end
        n_cmp++; if (first_err_idx !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL rst_first: got %h want ffffffff", first_err_idx); end
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
    endtask

    task automatic test_basic;
        int unsigned sc, lc, at; bit got, hi; exp_t e;
        drive_run(32'd0, 32'd4, 32'd4, 32'd0, 0, 0, 0, 1, sc, lc);
        collect(got, at, hi);
        e = sb.pop_front();
        n_cmp++; if (got !== 1'b1) begin n_err++; $display("FAIL basic_done: got %b want 1", got); end
        n_cmp++; if (at !== lc + 3) begin n_err++; $display("FAIL basic_latency: got %0d want %0d", at - lc, 3); end
        n_cmp++; if (hi !== 1'b0) begin n_err++; $display("FAIL basic_done_width: got %b want 0", hi); end
        n_cmp++; if (beat_cnt !== e.bc) begin n_err++; $display("FAIL basic_beat_cnt: got %h want %h", beat_cnt, e.bc); end
        n_cmp++; if (err_cnt !== e.ec) begin n_err++; $display("FAIL basic_err_cnt: got %h want %h", err_cnt, e.ec); end
        n_cmp++; if (first_err_idx !== e.fe) begin n_err++; $display("FAIL basic_first: got %h want %h", first_err_idx, e.fe); end
        repeat (5) @(negedge ap_clk);
        n_cmp++; if (beat_cnt !== e.bc || busy !== 1'b0) begin n_err++; $display("FAIL basic_hold: got %h/%b want %h/0", beat_cnt, busy, e.bc); end
    endtask

    task automatic test_wrap;
        int unsigned sc, lc, at; bit got, hi; exp_t e;
        drive_run(32'hFFFF_FFFC, 32'd2, 32'd2, 32'd0, 0, 0, 0, 1, sc, lc);
        collect(got, at, hi);
        e = sb.pop_front();
        n_cmp++; if (got !== 1'b1) begin n_err++; $display("FAIL wrap_done: got %b want 1", got); end
        n_cmp++; if (err_cnt !== e.ec || beat_cnt !== e.bc) begin n_err++; $display("FAIL wrap_counts: got %h/%h want %h/%h", err_cnt, beat_cnt, e.ec, e.bc); end
    endtask

    task automatic test_errors;
        int unsigned sc, lc, at; bit got, hi; exp_t e;
        drive_run(32'h0000_1000, 32'd5, 32'd5, 32'b01010, 0, 0, 0, 1, sc, lc);
        collect(got, at, hi);
        e = sb.pop_front();
        n_cmp++; if (got !== 1'b1) begin n_err++; $display("FAIL err_done: got %b want 1", got); end
        n_cmp++; if (err_cnt !== e.ec) begin n_err++; $display("FAIL err_cnt: got %h want %h", err_cnt, e.ec); end
        n_cmp++; if (first_err_idx !== e.fe) begin n_err++; $display("FAIL err_first: got %h want %h", first_err_idx, e.fe); end
    endtask

    task automatic test_zero;
        int unsigned sc, lc, at; bit got, hi; exp_t e;
        drive_run(32'h55, 32'd0, 32'd0, 32'd0, 0, 0, 0, 1, sc, lc);
        n_cmp++; if (rx_axis_tready !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL zero_tready: got %b/%b want 0/0", rx_axis_tready, busy); end
        collect(got, at, hi);
        e = sb.pop_front();
        n_cmp++; if (got !== 1'b1 || at !== sc + 1) begin n_err++; $display("FAIL zero_done: got %b@%0d want 1@%0d", got, at - sc, 1); end
        n_cmp++; if (beat_cnt !== e.bc || err_cnt !== e.ec) begin n_err++; $display("FAIL zero_counts: got %h/%h want %h/%h", beat_cnt, err_cnt, e.bc, e.ec); end
        n_cmp++; if (first_err_idx !== e.fe || rx_axis_tready !== 1'b0) begin n_err++; $display("FAIL zero_first: got %h/%b want %h/0", first_err_idx, rx_axis_tready, e.fe); end
    endtask

    task automatic test_back_to_back;
        int unsigned sc, lc, at; bit got, hi; exp_t e;
        for (int pass = 0; pass < 2; pass++) begin
            drive_run(32'h1234_5678, 32'd12, 32'd12, 32'h0000_0284, pass == 1, pass == 1, 0, 1, sc, lc);
            collect(got, at, hi);
            e = sb.pop_front();
            n_cmp++; if (got !== 1'b1) begin n_err++; $display("FAIL b2b%0d_done: got %b want 1", pass, got); end
            n_cmp++; if (beat_cnt !== e.bc) begin n_err++; $display("FAIL b2b%0d_beat_cnt: got %h want %h", pass, beat_cnt, e.bc); end
            n_cmp++; if (err_cnt !== e.ec) begin n_err++; $display("FAIL b2b%0d_err_cnt: got %h want %h", pass, err_cnt, e.ec); end
            n_cmp++; if (first_err_idx !== e.fe) begin n_err++; $display("FAIL b2b%0d_first: got %h want %h", pass, first_err_idx, e.fe); end
        end
    endtask

    task automatic test_reset_midrun;
        int unsigned sc, lc, n_done;
        drive_run(32'hA0A0_0000, 32'd8, 32'd2, 32'd1, 0, 0, 0, 0, sc, lc);
        repeat (3) @(negedge ap_clk);
        n_cmp++; if (err_cnt !== 32'd1 || busy !== 1'b1) begin n_err++; $display("FAIL mid_pre: got %h/%b want 1/1", err_cnt, busy); end
        #2 ap_rst_n = 1'b0;
        #1;
        n_cmp++; if ({rx_axis_tready, busy, done, timeout} !== 4'b0000) begin n_err++; $display("FAIL mid_flags: got %b want 0000", {rx_axis_tready, busy, done, timeout}); end
        n_cmp++; if (beat_cnt !== 32'd0 || err_cnt !== 32'd0 || first_err_idx !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL mid_counts: got %h/%h/%h want 0/0/ffffffff", beat_cnt, err_cnt, first_err_idx); end
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        n_done = 0;
        repeat (10) begin @(negedge ap_clk); if (done) n_done++; end
        n_cmp++; if (n_done !== 0 || err_cnt !== 32'd0) begin n_err++; $display("FAIL mid_nodone: got %0d/%h want 0/0", n_done, err_cnt); end
    endtask

    task automatic test_watchdog;
        int unsigned sc, lc, at; bit got, hi;
`ifdef CHK_TIMEOUT_EN
        exp_t e;
        drive_run(32'd5, 32'd8, 32'd3, 32'd0, 0, 0, 1, 1, sc, lc);
        collect(got, at, hi);
        e = sb.pop_front();
        n_cmp++; if (got !== 1'b1 || at !== lc + 18) begin n_err++; $display("FAIL wd_done: got %b@%0d want 1@18", got, at - lc); end
        n_cmp++; if (timeout !== e.to) begin n_err++; $display("FAIL wd_timeout: got %b want %b", timeout, e.to); end
        n_cmp++; if (beat_cnt !== e.bc || err_cnt !== e.ec) begin n_err++; $display("FAIL wd_counts: got %h/%h want %h/%h", beat_cnt, err_cnt, e.bc, e.ec); end
        drive_run(32'd5, 32'd8, 32'd2, 32'd0, 0, 0, 0, 0, sc, lc);
        #2 ap_rst_n = 1'b0;
        #1;
        n_cmp++; if ({timeout, busy, done} !== 3'b000 || beat_cnt !== 32'd0) begin n_err++; $display("FAIL wd_rst: got %b/%h want 000/0", {timeout, busy, done}, beat_cnt); end
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
`else
        int unsigned n_done;
        drive_run(32'd5, 32'd8, 32'd3, 32'd0, 0, 0, 0, 0, sc, lc);
        n_done = 0;
        repeat (60) begin @(negedge ap_clk); if (done) n_done++; end
        n_cmp++; if (n_done !== 0 || busy !== 1'b1 || rx_axis_tready !== 1'b1) begin n_err++; $display("FAIL nowd_wait: got %0d/%b/%b want 0/1/1", n_done, busy, rx_axis_tready); end
        n_cmp++; if (timeout !== 1'b0 || beat_cnt !== 32'd3) begin n_err++; $display("FAIL nowd_state: got %b/%h want 0/3", timeout, beat_cnt); end
        #2 ap_rst_n = 1'b0;
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        collect(got, at, hi);
        n_cmp++; if (got !== 1'b0) begin n_err++; $display("FAIL nowd_rst_done: got %b want 0", got); end
`endif
    endtask

    initial begin
        test_reset;
        test_basic;
        test_wrap;
        test_errors;
        test_zero;
        test_back_to_back;
        test_reset_midrun;
        test_watchdog;
        n_cmp++; if (sb.size() !== 0) begin n_err++; $display("FAIL sb_left: got %0d want 0", sb.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_time: got expired want finish");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/aurora_rx_checker.md
AURORA_RX_CHECKER -- requirements
Module: aurora_rx_checker

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 1048576, meaning the idle-cycle limit in RUN before abort (used only with CHK_TIMEOUT_EN).
REQ-002 SHALL have port ap_clk, input, 1, the single clock for all logic.
REQ-003 SHALL have port ap_rst_n, input, 1, reset, asynchronous, active-low.
REQ-004 SHALL have port rx_axis_tvalid, input, 1, receive stream valid.
REQ-005 SHALL have port rx_axis_tdata, input, 256, receive stream data: eight 32-bit words, word j in bits [32j+31:32j].
REQ-006 SHALL have port rx_axis_tready, output, 1, receive stream ready.
REQ-007 SHALL have port start, input, 1, single-cycle run request.
REQ-008 SHALL have port beat_num, input, 32, beats to check; sampled on accepted start.
REQ-009 SHALL have port seed, input, 32, pattern seed; sampled on accepted start.
REQ-010 SHALL have port busy, output, 1, high in RUN and DRAIN.
REQ-011 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-012 SHALL have port beat_cnt, output, 32, beats accepted in the current or last run.
REQ-013 SHALL have port err_cnt, output, 32, mismatching beats, saturating at 32'hFFFF_FFFF.
REQ-014 SHALL have port first_err_idx, output, 32, index of the first mismatching beat; 32'hFFFF_FFFF if none.
REQ-015 SHALL have port timeout, output, 1, sticky flag: last run aborted by watchdog.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, DRAIN, DONE.
REQ-017 IDLE: rx_axis_tready=0; start=1 with beat_num!=0 -> RUN, latch beat_num and seed, clear beat_cnt and err_cnt, set first_err_idx=32'hFFFF_FFFF, clear timeout.
REQ-018 IDLE: start=1 with beat_num==0 -> DONE with counters cleared; no beats consumed.
REQ-019 start SHALL be ignored outside IDLE.
REQ-020 RUN: rx_axis_tready=1; handshake = tvalid & tready; each handshake increments beat_cnt and registers the beat (stage 1).
REQ-021 Expected word j of beat k SHALL be seed + 8*k + j, modulo 2^32.
REQ-022 Compare SHALL occur in stage 2, one cycle after the handshake; err_cnt and first_err_idx SHALL update two cycles after the handshake.
REQ-023 A beat with one or more mismatching words SHALL count as one error; first_err_idx SHALL capture only the first error of the run.
REQ-024 Handshake of beat index beat_num-1 -> DRAIN, with rx_axis_tready=0 from the next cycle.
REQ-025 DRAIN SHALL last until the stage-2 result of the final beat is committed (2 cycles), then -> DONE.
REQ-026 DONE SHALL assert done for exactly one cycle, then -> IDLE; beat_cnt, err_cnt, first_err_idx, and timeout SHALL hold until the next accepted start.
REQ-027 beat_cnt SHALL wrap never: beat_num is at most 2^32-1, so no overflow.

Reset
REQ-028 While ap_rst_n=0: state=IDLE; rx_axis_tready=0, busy=0, done=0, timeout=0, beat_cnt=0, err_cnt=0, first_err_idx=32'hFFFF_FFFF; pipeline valid bits cleared.
REQ-029 Reset asserted mid-run SHALL abort immediately with no done pulse.

Configuration
REQ-030 With CHK_TIMEOUT_EN defined: in RUN, a counter SHALL count consecutive cycles without a handshake; it SHALL clear on each handshake.
REQ-031 With CHK_TIMEOUT_EN, when the counter reaches TIMEOUT_CYC: set timeout=1 and go to DRAIN (in-flight beats complete), then DONE.
REQ-032 Without CHK_TIMEOUT_EN: no watchdog logic; timeout SHALL be tied 0; RUN waits indefinitely.

Verification
REQ-033 seed=0, beat_num=4, correct pattern every cycle -> beat_cnt=4, err_cnt=0, first_err_idx=FFFF_FFFF, done pulse 2 cycles after the 4th handshake.
REQ-034 seed=32'hFFFF_FFFC, beat_num=2, correct pattern -> words wrap through 0; err_cnt=0.
REQ-035 beat_num=5, beats 1 and 3 corrupted (word 7 flipped) -> err_cnt=2, first_err_idx=1.
REQ-036 beat_num=0 with start -> done the next cycle, tready never asserted, beat_cnt=0.
REQ-037 tvalid toggling randomly, plus start pulses during RUN -> starts ignored; counts identical to back-to-back case.
REQ-038 CHK_TIMEOUT_EN, TIMEOUT_CYC=16, beat_num=8, only 3 beats sent -> timeout=1, beat_cnt=3, done asserted; ap_rst_n pulsed mid-run -> all outputs at reset values, no done.
